// File: rtl/readout_sequencer.sv
// Readout sequencer: visits masked channels, pulses their load, then hands
// each channel's words to the serial shifter. Optional watchdog: SEQ_TIMEOUT_EN.
module readout_sequencer #(
    parameter int NUM_CH       = 8,
    parameter int WORDS_PER_CH = 7,
    parameter int LOAD_CYCLES  = 2,
    parameter int BASE_ADDR    = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              iclk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_CH-1:0] trigger_channel_mask,
    output logic [NUM_CH-1:0] load_cnt_ser,
    output logic              load_pulse,
    output logic [2:0]        select_reg,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [7:0]        cur_addr,
    output logic              busy,
    output logic              done,
    output logic              timeout_flag
);

    localparam int CW = $clog2(NUM_CH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_LOAD,
        S_SHIFT,
        S_FIN
    } state_t;

    state_t            r_state;
    logic [NUM_CH-1:0] r_mask;
    logic [CW-1:0]     r_ch;
    logic [2:0]        r_word;
    logic [3:0]        r_lcnt;
    logic [NUM_CH-1:0] r_load;
    logic              r_lp;
    logic              r_valid;
    logic [7:0]        r_addr;
    logic              r_busy;
    logic              r_done;

    logic              w_found;
    logic [CW-1:0]     w_idx;
    logic [7:0]        w_base;
    logic              w_last;
    logic              w_xfer;
    logic              w_tmo;
    logic              w_adv;

    // Lowest masked channel at or above r_ch; skipped channels cost nothing
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_mask[i] && (CW'(i) >= r_ch)) begin
                w_found = 1'b1;
                w_idx   = CW'(i);
            end
        end
    end

    assign w_base = 8'(BASE_ADDR + int'(w_idx) * WORDS_PER_CH);
    assign w_last = (r_word == 3'(WORDS_PER_CH - 1));
    assign w_xfer = r_valid & word_ready;
    assign w_adv  = w_xfer | w_tmo;

`ifdef SEQ_TIMEOUT_EN
    logic [7:0] r_wait;
    logic       r_tflag;

    assign w_tmo = (r_state == S_SHIFT) && !word_ready
                   && (r_wait == 8'(TIMEOUT - 1));

    // Flag survives abort; only rstn clears it
    always_ff @(posedge iclk) begin
        if (!rstn) begin
            r_wait  <= '0;
            r_tflag <= 1'b0;
        end else begin
            if (w_tmo && !abort)
                r_tflag <= 1'b1;
            if (abort || r_state != S_SHIFT || word_ready || w_tmo)
                r_wait <= '0;
            else
                r_wait <= r_wait + 8'd1;
        end
    end

    assign timeout_flag = r_tflag;
`else
    assign w_tmo        = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_ff @(posedge iclk) begin
        if (!rstn || abort) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
            r_ch    <= '0;
            r_word  <= '0;
            r_lcnt  <= '0;
            r_load  <= '0;
            r_lp    <= 1'b0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mask  <= trigger_channel_mask;
                        r_ch    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_found) begin
                        r_ch    <= w_idx;
                        r_load  <= NUM_CH'(1) << w_idx;
                        r_lp    <= 1'b1;
                        r_lcnt  <= '0;
                        r_word  <= '0;
                        r_addr  <= w_base;
                        r_state <= S_LOAD;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end
                end
                S_LOAD: begin
                    if (r_lcnt == 4'(LOAD_CYCLES - 1)) begin
                        r_lp    <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_lcnt <= r_lcnt + 4'd1;
                    end
                end
                S_SHIFT: begin
                    if (w_adv) begin
                        if (!w_last) begin
                            r_word <= r_word + 3'd1;
                            r_addr <= r_addr + 8'd1;
                        end else begin
                            r_ch    <= r_ch + CW'(1);
                            r_load  <= '0;
                            r_valid <= 1'b0;
                            r_word  <= '0;
                            r_addr  <= '0;
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign load_cnt_ser = r_load;
    assign load_pulse   = r_lp;
    assign select_reg   = r_word;
    assign word_valid   = r_valid;
    assign cur_addr     = r_addr;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_readout_sequencer.sv
// Randomized bench for readout_sequencer against a transfer-list model
// built from the mask (channel order, word order, address numbering).
module tb_readout_sequencer;

    localparam int NCH  = 8;
    localparam int W    = 7;
    localparam int LC   = 2;
    localparam int BASE = 4;

    logic           iclk = 1'b0;
    logic           rstn;
    logic           start;
    logic           abort;
    logic [NCH-1:0] trigger_channel_mask;
    logic [NCH-1:0] load_cnt_ser;
    logic           load_pulse;
    logic [2:0]     select_reg;
    logic           word_valid;
    logic           word_ready;
    logic [7:0]     cur_addr;
    logic           busy;
    logic           done;
    logic           timeout_flag;

    int n_chk = 0;
    int n_err = 0;

    readout_sequencer dut (
        .iclk                 (iclk),
        .rstn                 (rstn),
        .start                (start),
        .abort                (abort),
        .trigger_channel_mask (trigger_channel_mask),
        .load_cnt_ser         (load_cnt_ser),
        .load_pulse           (load_pulse),
        .select_reg           (select_reg),
        .word_valid           (word_valid),
        .word_ready           (word_ready),
        .cur_addr             (cur_addr),
        .busy                 (busy),
        .done                 (done),
        .timeout_flag         (timeout_flag)
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_lcs"}, 32'(load_cnt_ser), 0);
        chk({tag, "_lp"}, 32'(load_pulse), 0);
        chk({tag, "_vld"}, 32'(word_valid), 0);
        chk({tag, "_sel"}, 32'(select_reg), 0);
        chk({tag, "_addr"}, 32'(cur_addr), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // rmode: 0 ready always, 1 random ready, 2 pattern 1,0,0
    task automatic run(input logic [7:0] m, input int rmode,
                       input int abort_addr, input int bstart_k);
        int  exp_q[$];
        int  e, k, done_k, n_xfer, n_load, pc;
        bit  got_done, aborted, rdy;
        exp_q.delete();
        for (int c = 0; c < NCH; c++)
            if (m[c])
                for (int w = 0; w < W; w++)
                    exp_q.push_back(BASE + c * W + w);
        pc = $countones(m);
        n_xfer = 0; n_load = 0; done_k = 0;
        got_done = 0; aborted = 0;
        @(negedge iclk);
        trigger_channel_mask = m;
        start = 1'b1;
        @(negedge iclk);
        start = 1'b0;
        trigger_channel_mask = 8'($urandom);
        k = 1;
        while (k < 3000 && !got_done && !aborted) begin
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom % 2);
                default: rdy = (k % 3 == 1);
            endcase
            start = (k == bstart_k);
            if (load_pulse) n_load++;
            if (done) begin
                got_done = 1;
                done_k = k;
                chk("busy_at_done", 32'(busy), 0);
            end
            if (word_valid && abort_addr != 0 && cur_addr == abort_addr) begin
                abort = 1'b1;
                rdy = 1'b0;
                aborted = 1;
            end else if (word_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 32'(cur_addr), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("addr", 32'(cur_addr), e);
                    chk("sel", 32'(select_reg), (e - BASE) % W);
                    chk("lcs", 32'(load_cnt_ser), 1 << ((e - BASE) / W));
                end
                n_xfer++;
            end
            word_ready = rdy;
            @(negedge iclk);
            k++;
        end
        start = 1'b0;
        word_ready = 1'b0;
        if (aborted) begin
            abort = 1'b0;
            chk_idle("abort");
            @(negedge iclk);
            chk("abort_nodone", 32'(done), 0);
        end else begin
            chk("got_done", 32'(got_done), 1);
            chk("n_xfer", n_xfer, pc * W);
            chk("left", exp_q.size(), 0);
            chk("n_load", n_load, pc * LC);
            if (rmode == 0)
                chk("done_cyc", done_k, 2 + pc * (1 + LC + W));
            chk_idle("post");
        end
    endtask

    task automatic rst_mid_load();
        int k;
        @(negedge iclk);
        trigger_channel_mask = 8'hFF;
        start = 1'b1;
        @(negedge iclk);
        start = 1'b0;
        k = 0;
        while (!load_pulse && k < 20) begin
            @(negedge iclk);
            k++;
        end
        chk("rst_lp_seen", 32'(load_pulse), 1);
        rstn = 1'b0;
        @(negedge iclk);
        chk_idle("rst_load");
        chk("rst_tflag", 32'(timeout_flag), 0);
        rstn = 1'b1;
    endtask

    task automatic stall_test();
        int k;
        @(negedge iclk);
        trigger_channel_mask = 8'h01;
        start = 1'b1;
        word_ready = 1'b1;
        @(negedge iclk);
        start = 1'b0;
        k = 0;
        while (!(word_valid && cur_addr == 8'd6) && k < 50) begin
            @(negedge iclk);
            k++;
        end
        chk("w2_seen", 32'(cur_addr), 6);
        word_ready = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        repeat (254) @(negedge iclk);
        chk("tmo_pre_flag", 32'(timeout_flag), 0);
        chk("tmo_pre_addr", 32'(cur_addr), 6);
        @(negedge iclk);
        chk("tmo_flag", 32'(timeout_flag), 1);
        chk("tmo_addr", 32'(cur_addr), 7);
        chk("tmo_sel", 32'(select_reg), 3);
        word_ready = 1'b1;
        k = 0;
        while (!done && k < 50) begin
            @(negedge iclk);
            k++;
        end
        chk("tmo_done", 32'(done), 1);
        chk("tmo_flag_done", 32'(timeout_flag), 1);
        word_ready = 1'b0;
        run(8'h00, 0, 0, 0);
        chk("tmo_flag_start", 32'(timeout_flag), 1);
        rstn = 1'b0;
        @(negedge iclk);
        chk("tmo_flag_rst", 32'(timeout_flag), 0);
        rstn = 1'b1;
`else
        repeat (300) @(negedge iclk);
        chk("stall_addr", 32'(cur_addr), 6);
        chk("stall_vld", 32'(word_valid), 1);
        chk("stall_tflag", 32'(timeout_flag), 0);
        abort = 1'b1;
        @(negedge iclk);
        abort = 1'b0;
        chk_idle("stall_abort");
`endif
    endtask

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        word_ready = 1'b0;
        trigger_channel_mask = '0;
        repeat (3) @(negedge iclk);
        chk_idle("reset");
        chk("reset_tflag", 32'(timeout_flag), 0);
        rstn = 1'b1;

        run(8'hFF, 0, 0, 0);
        run(8'b0010_1001, 0, 0, 0);
        run(8'h01, 2, 0, 0);
        run(8'h00, 0, 0, 0);
        run(8'hFF, 0, BASE + 3 * W + 4, 0);
        run(8'hFF, 0, 0, 7);
        rst_mid_load();
        for (int i = 0; i < 6; i++)
            run(8'($urandom), 1, 0, 5);
        stall_test();
        run(8'b1000_0010, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
